icache_loader: RTL and testbench
================================

# icache_loader

Boot-time fill engine for the L1 instruction cache. Receives a byte-serial program image over a valid/ready stream, assembles 60-bit instructions and drives the cache's write port (write enable, 16-bit address, 60-bit instruction) one instruction at a time. Holds the core's fetch pipeline in reset until the image is fully written. It sits between the external boot link and the `l1i_Cache` write inputs.

## Interface
- NUM_ENTRIES, 257, number of i-cache lines; the highest writable address is NUM_ENTRIES-1.
- clock_i  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- rxData_i  in  8  incoming image byte.
- rxValid_i  in  1  rxData_i valid this cycle.
- rxReady_o  out  1  loader accepts a byte this cycle; transfer occurs when rxValid_i && rxReady_o at a clock edge.
- writeEnable_o  out  1  one-cycle write strobe to the cache.
- writeAddress_o  out  16  cache line address for the current strobe.
- instruction_o  out  60  instruction data for the current strobe.
- coreHold_o  out  1  1 = core/fetch held in reset; drives the cache reset_i.
- done_o  out  1  image loaded successfully; sticky.
- error_o  out  1  header rejected; sticky.

## Operation
- Stream format, bytes in order: ADDR_HI, ADDR_LO (start address, big-endian), CNT_HI, CNT_LO (instruction count N, big-endian), then N × 8 data bytes per instruction.
- Instruction packing: first data byte's bits [3:0] → instruction[59:56], upper nibble ignored; bytes 2..8 → [55:48] … [7:0]. Implemented as a 64-bit shift-left-by-8 register; instruction_o = shift[59:0].
- States: S_ADDR_HI, S_ADDR_LO, S_CNT_HI, S_CNT_LO, S_DATA, S_WRITE, S_DONE, S_ERROR.
- S_ADDR_HI→S_ADDR_LO→S_CNT_HI→S_CNT_LO: advance on each accepted byte, latching the address/count halves.
- On accepting CNT_LO: compute a 17-bit sum = start + N. If sum > NUM_ENTRIES → S_ERROR. Else if N == 0 → S_DONE. Else → S_DATA with byteCnt = 0, remaining = N, address counter = start.
- S_DATA: each accepted byte shifts in and increments the 3-bit byteCnt. On the 8th byte (byteCnt == 7) → S_WRITE.
- S_WRITE: one cycle; writeEnable_o = 1 with writeAddress_o = address counter and instruction_o = assembled word. Leaving S_WRITE: address counter += 1, remaining -= 1; if remaining becomes 0 → S_DONE, else → S_DATA with byteCnt = 0.
- S_DONE: coreHold_o = 0, done_o = 1; all further bytes are refused. Stays here until reset.
- S_ERROR: error_o = 1, coreHold_o stays 1, no writes, bytes refused; stays until reset.
- rxReady_o = 1 only in S_ADDR_HI..S_CNT_LO and S_DATA.
- No arithmetic wraps: the range check guarantees address counter ≤ NUM_ENTRIES-1 at every strobe.
- Boundary condition: start + N == NUM_ENTRIES is legal (the last line is written).

## Timing
- Reset (reset == 0 at an edge): state = S_ADDR_HI, rxReady_o = 0, writeEnable_o = 0, writeAddress_o = 0, instruction_o = 0, coreHold_o = 1, done_o = 0, error_o = 0, byteCnt = 0. rxReady_o rises the cycle after reset is released.
- Reset mid-operation: the partial word and header are discarded. Lines already written to the cache are not touched.
- All outputs are registered.
- writeEnable_o is high for exactly one cycle, beginning the cycle after the 8th data byte is accepted. rxReady_o is low during that cycle.
- Throughput: at most one instruction per 9 cycles with rxValid_i held high.
- rxValid_i may drop at any byte boundary; the loader simply waits, with no timeout.
- done_o and coreHold_o fall/rise in the cycle after the last S_WRITE (or after CNT_LO when N = 0).
- error_o rises the cycle after CNT_LO is accepted.

## Test plan
- Load 2 instructions at 0x0010 (bytes 00 10 00 02, then 0F FF … FF, then 01 23 45 67 89 AB CD EF) → two strobes:
  - addr 0x0010, data 0xFFFFFFFFFFFFFFF
  - addr 0x0011, data 0x123456789ABCDEF
  - done_o = 1 and coreHold_o = 0 one cycle after the second strobe.
- Count 0 (00 05 00 00) → no strobes; done_o = 1 the cycle after CNT_LO; rxReady_o = 0 afterwards.
- Range boundary:
  - start 0x0100, N = 1 → one strobe at 0x0100, done.
  - start 0x0100, N = 2 → error_o = 1, no strobes, coreHold_o stays 1.
- Random rxValid_i gaps (30% idle) during a 4-instruction load at 0x0000 → strobes at 0..3 with correct data; no strobe until all 8 bytes of a word have been accepted.
- Assert reset after 5 data bytes of the first word, then send a new image (start 0x0020, N = 1) → a single strobe at 0x0020 with the new data only.
- Upper nibble of the first data byte set (0xF3) → instruction[59:56] = 0x3; the upper nibble is ignored.

Source files
------------

// File: rtl/icache_loader.sv
// Boot-time fill engine for the L1 instruction cache: turns a byte-serial image
// (addr, count, 8 bytes per instruction) into single-cycle cache write strobes.
module icache_loader #(
    parameter int unsigned NUM_ENTRIES = 257
) (
    input  logic        clock_i,
    input  logic        reset,
    input  logic [7:0]  rxData_i,
    input  logic        rxValid_i,
    output logic        rxReady_o,
    output logic        writeEnable_o,
    output logic [15:0] writeAddress_o,
    output logic [59:0] instruction_o,
    output logic        coreHold_o,
    output logic        done_o,
    output logic        error_o
);

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned SUM_W  = ADDR_W + 1;
    localparam int unsigned PART_W = 52;

    typedef enum logic [2:0] {
        S_ADDR_HI,
        S_ADDR_LO,
        S_CNT_HI,
        S_CNT_LO,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t              state;
    logic [7:0]          hi_byte;
    logic [ADDR_W-1:0]   start_addr;
    logic [ADDR_W-1:0]   remaining;
    logic [ADDR_W-1:0]   addr_cnt;
    logic [2:0]          byte_cnt;
    logic [PART_W-1:0]   partial;

    logic                accept_c;
    logic [ADDR_W-1:0]   count_c;
    logic [SUM_W-1:0]    sum_c;

    assign accept_c = rxValid_i && rxReady_o;
    assign count_c  = {hi_byte, rxData_i};
    assign sum_c    = {1'b0, start_addr} + {1'b0, count_c};

    // Partial word keeps only the 52 bits that survive into the instruction:
    // low nibble of the first data byte plus the next six bytes.
    always_ff @(posedge clock_i) begin
        if (!reset) begin
            state          <= S_ADDR_HI;
            hi_byte        <= '0;
            start_addr     <= '0;
            remaining      <= '0;
            addr_cnt       <= '0;
            byte_cnt       <= '0;
            partial        <= '0;
            rxReady_o      <= 1'b0;
            writeEnable_o  <= 1'b0;
            writeAddress_o <= '0;
            instruction_o  <= '0;
            coreHold_o     <= 1'b1;
            done_o         <= 1'b0;
            error_o        <= 1'b0;
        end else begin
            writeEnable_o <= 1'b0;
            case (state)
                S_ADDR_HI: begin
                    rxReady_o <= 1'b1;
                    if (accept_c) begin
                        hi_byte <= rxData_i;
                        state   <= S_ADDR_LO;
                    end
                end
                S_ADDR_LO: begin
                    rxReady_o <= 1'b1;
                    if (accept_c) begin
                        start_addr <= {hi_byte, rxData_i};
                        state      <= S_CNT_HI;
                    end
                end
                S_CNT_HI: begin
                    rxReady_o <= 1'b1;
                    if (accept_c) begin
                        hi_byte <= rxData_i;
                        state   <= S_CNT_LO;
                    end
                end
                S_CNT_LO: begin
                    rxReady_o <= 1'b1;
                    if (accept_c) begin
                        if (sum_c > SUM_W'(NUM_ENTRIES)) begin
                            state     <= S_ERROR;
                            error_o   <= 1'b1;
                            rxReady_o <= 1'b0;
                        end else if (count_c == '0) begin
                            state      <= S_DONE;
                            done_o     <= 1'b1;
                            coreHold_o <= 1'b0;
                            rxReady_o  <= 1'b0;
                        end else begin
                            state     <= S_DATA;
                            byte_cnt  <= '0;
                            remaining <= count_c;
                            addr_cnt  <= start_addr;
                        end
                    end
                end
                S_DATA: begin
                    rxReady_o <= 1'b1;
                    if (accept_c) begin
                        partial  <= {partial[PART_W-9:0], rxData_i};
                        byte_cnt <= byte_cnt + 3'd1;
                        if (byte_cnt == 3'd7) begin
                            state          <= S_WRITE;
                            rxReady_o      <= 1'b0;
                            writeEnable_o  <= 1'b1;
                            writeAddress_o <= addr_cnt;
                            instruction_o  <= {partial, rxData_i};
                        end
                    end
                end
                S_WRITE: begin
                    addr_cnt  <= addr_cnt + 16'd1;
                    remaining <= remaining - 16'd1;
                    if (remaining == 16'd1) begin
                        state      <= S_DONE;
                        done_o     <= 1'b1;
                        coreHold_o <= 1'b0;
                        rxReady_o  <= 1'b0;
                    end else begin
                        state     <= S_DATA;
                        byte_cnt  <= '0;
                        rxReady_o <= 1'b1;
                    end
                end
                S_DONE: begin
                    rxReady_o <= 1'b0;
                end
                S_ERROR: begin
                    rxReady_o <= 1'b0;
                end
                default: begin
                    state     <= S_ADDR_HI;
                    rxReady_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_loader.sv
// Directed self-checking bench for icache_loader: header parsing, packing,
// range boundary, idle gaps on the stream and reset mid-image.
module tb_icache_loader;

    logic        clock_i = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rxData_i = 8'h00;
    logic        rxValid_i = 1'b0;
    logic        rxReady_o;
    logic        writeEnable_o;
    logic [15:0] writeAddress_o;
    logic [59:0] instruction_o;
    logic        coreHold_o;
    logic        done_o;
    logic        error_o;

    icache_loader #(.NUM_ENTRIES(257)) dut (
        .clock_i        (clock_i),
        .reset          (reset),
        .rxData_i       (rxData_i),
        .rxValid_i      (rxValid_i),
        .rxReady_o      (rxReady_o),
        .writeEnable_o  (writeEnable_o),
        .writeAddress_o (writeAddress_o),
        .instruction_o  (instruction_o),
        .coreHold_o     (coreHold_o),
        .done_o         (done_o),
        .error_o        (error_o)
    );

    always #5 clock_i = ~clock_i;

    int   n_checks = 0;
    int   n_errors = 0;
    int   strobes = 0;
    int   bad_pulse = 0;
    logic prev_we = 1'b0;
    int   s0;

    logic [63:0] t5_words [4] = '{64'h0102_0304_0506_0708, 64'hA1B2_C3D4_E5F6_0718,
                                  64'h5C00_0000_0000_0001, 64'h8080_8080_8080_8080};
    logic [59:0] t5_exp   [4] = '{60'h102_0304_0506_0708, 60'h1B2_C3D4_E5F6_0718,
                                  60'hC00_0000_0000_0001, 60'h080_8080_8080_8080};

    // Strobe counter; a strobe must last one cycle and never overlap rxReady_o.
    always @(negedge clock_i) begin
        if (writeEnable_o) strobes <= strobes + 1;
        if (writeEnable_o && (prev_we || rxReady_o)) bad_pulse <= bad_pulse + 1;
        prev_we <= writeEnable_o;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Presents one byte at a negedge and returns at the negedge after it is taken.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited = 0;
        int idles = 0;
        while (gap > 0 && idles < 20 && int'($urandom_range(99)) < gap) begin
            rxValid_i = 1'b0;
            @(negedge clock_i);
            idles++;
        end
        rxData_i  = b;
        rxValid_i = 1'b1;
        while (!rxReady_o && waited < 40) begin
            @(negedge clock_i);
            waited++;
        end
        if (!rxReady_o) check("rx_timeout", 64'(rxReady_o), 64'd1);
        else @(negedge clock_i);
        rxValid_i = 1'b0;
    endtask

    task automatic send_hdr(input logic [15:0] a, input logic [15:0] n, input int gap);
        send_byte(a[15:8], gap);
        send_byte(a[7:0], gap);
        send_byte(n[15:8], gap);
        send_byte(n[7:0], gap);
    endtask

    task automatic send_word(input logic [63:0] w, input int gap);
        for (int j = 0; j < 8; j++) begin
            logic [7:0] b;
            b = w[63-8*j -: 8];
            send_byte(b, gap);
        end
    endtask

    task automatic check_strobe(input string tag, input logic [15:0] a, input logic [59:0] d);
        check({tag, "_we"},    64'(writeEnable_o), 64'd1);
        check({tag, "_addr"},  64'(writeAddress_o), 64'(a));
        check({tag, "_data"},  64'(instruction_o), 64'(d));
        check({tag, "_ready"}, 64'(rxReady_o), 64'd0);
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        rxValid_i = 1'b0;
        repeat (2) @(negedge clock_i);
        reset = 1'b1;
        @(negedge clock_i);
    endtask

    initial begin
        // Reset values
        repeat (2) @(negedge clock_i);
        check("rst_ready", 64'(rxReady_o), 64'd0);
        check("rst_we",    64'(writeEnable_o), 64'd0);
        check("rst_addr",  64'(writeAddress_o), 64'd0);
        check("rst_instr", 64'(instruction_o), 64'd0);
        check("rst_hold",  64'(coreHold_o), 64'd1);
        check("rst_done",  64'(done_o), 64'd0);
        check("rst_err",   64'(error_o), 64'd0);
        reset = 1'b1;
        @(negedge clock_i);
        check("ready_after_rst", 64'(rxReady_o), 64'd1);

        // Two instructions at 0x0010
        s0 = strobes;
        send_hdr(16'h0010, 16'd2, 0);
        check("t1_hold_hdr", 64'(coreHold_o), 64'd1);
        send_word(64'h0FFF_FFFF_FFFF_FFFF, 0);
        check_strobe("t1_w0", 16'h0010, 60'hFFF_FFFF_FFFF_FFFF);
        @(negedge clock_i);
        check("t1_we_drop",  64'(writeEnable_o), 64'd0);
        check("t1_ready_up", 64'(rxReady_o), 64'd1);
        check("t1_done_mid", 64'(done_o), 64'd0);
        send_word(64'h0123_4567_89AB_CDEF, 0);
        check_strobe("t1_w1", 16'h0011, 60'h123_4567_89AB_CDEF);
        @(negedge clock_i);
        check("t1_done", 64'(done_o), 64'd1);
        check("t1_hold", 64'(coreHold_o), 64'd0);
        check("t1_ready_done", 64'(rxReady_o), 64'd0);
        #1;
        check("t1_strobes", 64'(strobes - s0), 64'd2);

        // Count zero
        do_reset();
        s0 = strobes;
        check("t2_done_cleared", 64'(done_o), 64'd0);
        send_hdr(16'h0005, 16'd0, 0);
        check("t2_done", 64'(done_o), 64'd1);
        check("t2_hold", 64'(coreHold_o), 64'd0);
        check("t2_ready", 64'(rxReady_o), 64'd0);
        rxData_i  = 8'h55;
        rxValid_i = 1'b1;
        repeat (4) @(negedge clock_i);
        check("t2_refuse", 64'(rxReady_o), 64'd0);
        check("t2_done_sticky", 64'(done_o), 64'd1);
        rxValid_i = 1'b0;
        #1;
        check("t2_strobes", 64'(strobes - s0), 64'd0);

        // Boundary: last line legal; upper nibble of first byte ignored
        do_reset();
        s0 = strobes;
        send_hdr(16'h0100, 16'd1, 0);
        send_word(64'hF311_2233_4455_6677, 0);
        check_strobe("t3_w0", 16'h0100, 60'h311_2233_4455_6677);
        @(negedge clock_i);
        check("t3_done", 64'(done_o), 64'd1);
        check("t3_hold", 64'(coreHold_o), 64'd0);
        #1;
        check("t3_strobes", 64'(strobes - s0), 64'd1);

        // Boundary: one past the end is rejected
        do_reset();
        s0 = strobes;
        send_hdr(16'h0100, 16'd2, 0);
        check("t4_err", 64'(error_o), 64'd1);
        check("t4_hold", 64'(coreHold_o), 64'd1);
        check("t4_ready", 64'(rxReady_o), 64'd0);
        check("t4_done", 64'(done_o), 64'd0);
        repeat (3) @(negedge clock_i);
        check("t4_err_sticky", 64'(error_o), 64'd1);
        #1;
        check("t4_strobes", 64'(strobes - s0), 64'd0);

        // Four instructions at 0x0000 with idle gaps on the stream
        do_reset();
        s0 = strobes;
        send_hdr(16'h0000, 16'd4, 30);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 7; j++) begin
                logic [7:0] b;
                b = t5_words[i][63-8*j -: 8];
                send_byte(b, 30);
            end
            #1;
            check("t5_no_early", 64'(strobes - s0), 64'(i));
            send_byte(t5_words[i][7:0], 30);
            check_strobe("t5_w", 16'(i), t5_exp[i]);
        end
        @(negedge clock_i);
        check("t5_done", 64'(done_o), 64'd1);
        #1;
        check("t5_strobes", 64'(strobes - s0), 64'd4);

        // Reset after five data bytes, then a fresh image
        do_reset();
        s0 = strobes;
        send_hdr(16'h0030, 16'd2, 0);
        for (int j = 0; j < 5; j++) send_byte(8'(8'h11 + j), 0);
        do_reset();
        check("t6_ready", 64'(rxReady_o), 64'd1);
        check("t6_hold", 64'(coreHold_o), 64'd1);
        send_hdr(16'h0020, 16'd1, 0);
        send_word(64'h0A5A_5A5A_5A5A_5A5A, 0);
        check_strobe("t6_w0", 16'h0020, 60'hA5A_5A5A_5A5A_5A5A);
        @(negedge clock_i);
        check("t6_done", 64'(done_o), 64'd1);
        #1;
        check("t6_strobes", 64'(strobes - s0), 64'd1);

        check("strobe_shape", 64'(bad_pulse), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
